// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, one outstanding imem fetch, feeds IF/ID.
// Optional FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_id,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  if_fetch_unit_if.master       imem,
  output logic [31:0]           instr_if,
  output logic [31:0]           pc_if,
  output logic [31:0]           pc_plus4_if,
  output logic                  if_valid,
  output logic                  fetch_misalign
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcif_q, pcif_d;
  logic        valid_q, valid_d;
  logic        kill_q, kill_d;
  logic        mis_q, mis_d;
  logic [31:0] tgt;
  logic        bad_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt     = redirect_pc;
  assign bad_tgt = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign tgt        = {redirect_pc[31:2], 2'b00};
  assign bad_tgt    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcif_d  = pcif_q;
    valid_d = valid_q;
    kill_d  = kill_q;
    mis_d   = mis_q;

    unique case (state_q)
      S_REQ: begin
        if (imem.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem.imem_rsp_data;
            pcif_d  = pc_q;
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // a stale reply can only land here after a misalign trap
        if (imem.imem_rsp_valid) kill_d = 1'b0;
        if (!stall_id && !mis_q) begin
          instr_d = BUBBLE_INSTR;
          pcif_d  = 32'd0;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      pc_d    = tgt;
      instr_d = BUBBLE_INSTR;
      pcif_d  = 32'd0;
      valid_d = 1'b0;
      mis_d   = 1'b0;
      if (state_d == S_HOLD) state_d = S_REQ;
      unique case (state_q)
        S_REQ:   if (imem.imem_req_ready) kill_d = 1'b1;
        S_WAIT:  kill_d = !imem.imem_rsp_valid;
        default: ;
      endcase
      if (bad_tgt) begin
        instr_d = BUBBLE_INSTR;
        pcif_d  = redirect_pc;
        valid_d = 1'b1;
        mis_d   = 1'b1;
        state_d = S_HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= BUBBLE_INSTR;
      pcif_q  <= 32'd0;
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcif_q  <= pcif_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
      mis_q   <= mis_d;
    end
  end

  assign imem.imem_req_valid = (state_q == S_REQ) && !reset;
  assign imem.imem_req_addr  = pc_q;

  assign instr_if       = instr_q;
  assign pc_if          = pcif_q;
  assign pc_plus4_if    = valid_q ? (pcif_q + 32'd4) : 32'd0;
  assign if_valid       = valid_q;
  assign fetch_misalign = mis_q;

endmodule
